// File: rtl/miriscv_arb_pkg.sv
// ---------------------------------------------------------------------------
// miriscv_arb_pkg
// Types and encodings for the instruction/data memory arbiter.
//   arb_state_e  : arbiter FSM state.
//   MASTER_INSTR : index of the fetch master in request/grant vectors.
//   MASTER_DATA  : index of the LSU master in request/grant vectors.
// ---------------------------------------------------------------------------
package miriscv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GNT_INSTR = 2'd1,
        GNT_DATA  = 2'd2
    } arb_state_e;

    // One-bit master indices; also the encoding of the last-grant register.
    localparam logic MASTER_INSTR = 1'b0;
    localparam logic MASTER_DATA  = 1'b1;

endpackage : miriscv_arb_pkg

// File: rtl/miriscv_pkg.sv
// ---------------------------------------------------------------------------
// miriscv_pkg
// Core-wide constants shared by the miriscv blocks.
//   XLEN : architectural register / bus width.
// ---------------------------------------------------------------------------
package miriscv_pkg;

    localparam int XLEN = 32;

endpackage : miriscv_pkg

// File: rtl/miriscv_rr_arb2.sv
// ---------------------------------------------------------------------------
// miriscv_rr_arb2
// Two-way combinational picker for the memory arbiter.
//   DATA_PRIO : 0 = round-robin on ties, 1 = data master always wins ties.
//   req       : in  [1:0] request vector, indexed by MASTER_INSTR/MASTER_DATA.
//   last_gnt  : in  master granted most recently (MASTER_* encoding).
//   gnt       : out [1:0] one-hot grant (all zero when nothing requests).
// ---------------------------------------------------------------------------
module miriscv_rr_arb2
    import miriscv_arb_pkg::*;
#(
    parameter bit DATA_PRIO = 1'b0
) (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[MASTER_INSTR] && req[MASTER_DATA]) begin
            // Tie: data wins under fixed priority, otherwise whoever was
            // not served last.
            if (DATA_PRIO || (last_gnt == MASTER_INSTR)) begin
                gnt[MASTER_DATA] = 1'b1;
            end else begin
                gnt[MASTER_INSTR] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

endmodule : miriscv_rr_arb2

// File: rtl/miriscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// miriscv_mem_arbiter
// Shares one memory port between the instruction fetch unit and the LSU.
// Exactly one transaction is outstanding at a time; the winner's request
// fields are latched at grant and held on the memory port for the whole
// grant.
//   DATA_PRIO      : 0 = round-robin ties, 1 = data master wins ties.
//   clk_i, arstn_i : clock, asynchronous active-low reset.
//   instr_*        : fetch master (req/addr in, rvalid/rdata out).
//   data_*         : LSU master (req/we/be/addr/wdata in, rvalid/rdata out).
//   mem_*_o        : shared memory request fields.
//   mem_rvalid_i,
//   mem_rdata_i    : shared memory response.
// ---------------------------------------------------------------------------
module miriscv_mem_arbiter
    import miriscv_pkg::*;
    import miriscv_arb_pkg::*;
#(
    parameter bit DATA_PRIO = 1'b0
) (
    input  logic                clk_i,
    input  logic                arstn_i,

    input  logic                instr_req_i,
    input  logic [XLEN-1:0]     instr_addr_i,
    output logic                instr_rvalid_o,
    output logic [XLEN-1:0]     instr_rdata_o,

    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [XLEN/8-1:0]   data_be_i,
    input  logic [XLEN-1:0]     data_addr_i,
    input  logic [XLEN-1:0]     data_wdata_i,
    output logic                data_rvalid_o,
    output logic [XLEN-1:0]     data_rdata_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [XLEN/8-1:0]   mem_be_o,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    input  logic                mem_rvalid_i,
    input  logic [XLEN-1:0]     mem_rdata_i
);

    arb_state_e              state;
    logic                    last_gnt;
    logic                    abort;
    logic                    lat_we;
    logic [XLEN/8-1:0]       lat_be;
    logic [XLEN-1:0]         lat_addr;
    logic [XLEN-1:0]         lat_wdata;

    logic [1:0]              req_vec;
    logic [1:0]              gnt;
    logic                    owner_req;

    always_comb begin
        req_vec               = 2'b00;
        req_vec[MASTER_INSTR] = instr_req_i;
        req_vec[MASTER_DATA]  = data_req_i;
    end

    miriscv_rr_arb2 #(
        .DATA_PRIO (DATA_PRIO)
    ) u_pick (
        .req      (req_vec),
        .last_gnt (last_gnt),
        .gnt      (gnt)
    );

    // Request line of the master currently holding the grant.
    always_comb begin
        owner_req = 1'b0;
        case (state)
            GNT_INSTR: owner_req = instr_req_i;
            GNT_DATA:  owner_req = data_req_i;
            default:   owner_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state     <= IDLE;
            last_gnt  <= MASTER_INSTR;
            abort     <= 1'b0;
            lat_we    <= 1'b0;
            lat_be    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    abort <= 1'b0;
                    if (gnt[MASTER_DATA]) begin
                        state     <= GNT_DATA;
                        last_gnt  <= MASTER_DATA;
                        lat_we    <= data_we_i;
                        lat_be    <= data_be_i;
                        lat_addr  <= data_addr_i;
                        lat_wdata <= data_wdata_i;
                    end else if (gnt[MASTER_INSTR]) begin
                        // Fetches are always full-word reads.
                        state     <= GNT_INSTR;
                        last_gnt  <= MASTER_INSTR;
                        lat_we    <= 1'b0;
                        lat_be    <= '1;
                        lat_addr  <= instr_addr_i;
                        lat_wdata <= '0;
                    end
                end
                GNT_INSTR, GNT_DATA: begin
                    if (mem_rvalid_i) begin
                        state <= IDLE;
                        abort <= 1'b0;
                    end else if (!owner_req) begin
                        // Killed by the owner: the memory access still has
                        // to drain, but its response must not be delivered.
                        abort <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req_o   = (state != IDLE) & ~mem_rvalid_i;
    assign mem_we_o    = lat_we;
    assign mem_be_o    = lat_be;
    assign mem_addr_o  = lat_addr;
    assign mem_wdata_o = lat_wdata;

    // A response reaches a master only if it owns the grant, has not killed
    // the transaction earlier, and is still requesting in the response cycle.
    assign instr_rvalid_o = (state == GNT_INSTR) & mem_rvalid_i & ~abort & instr_req_i;
    assign data_rvalid_o  = (state == GNT_DATA)  & mem_rvalid_i & ~abort & data_req_i;

    assign instr_rdata_o = mem_rdata_i;
    assign data_rdata_o  = mem_rdata_i;

endmodule : miriscv_mem_arbiter

// File: tb/tb_miriscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_miriscv_mem_arbiter
// Directed bench for the memory arbiter. Two instances share all inputs:
// u_dut0 uses round-robin ties, u_dut1 uses fixed data priority.
// ---------------------------------------------------------------------------
module tb_miriscv_mem_arbiter;
    import miriscv_pkg::*;

    logic              clk;
    logic              arstn;
    logic              instr_req;
    logic [XLEN-1:0]   instr_addr;
    logic              data_req;
    logic              data_we;
    logic [XLEN/8-1:0] data_be;
    logic [XLEN-1:0]   data_addr;
    logic [XLEN-1:0]   data_wdata;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    logic              instr_rvalid0, data_rvalid0, mem_req0, mem_we0;
    logic [XLEN-1:0]   instr_rdata0, data_rdata0, mem_addr0, mem_wdata0;
    logic [XLEN/8-1:0] mem_be0;

    logic              instr_rvalid1, data_rvalid1, mem_req1, mem_we1;
    logic [XLEN-1:0]   instr_rdata1, data_rdata1, mem_addr1, mem_wdata1;
    logic [XLEN/8-1:0] mem_be1;

    int checks = 0;
    int errors = 0;

    miriscv_mem_arbiter #(.DATA_PRIO(1'b0)) u_dut0 (
        .clk_i          (clk),
        .arstn_i        (arstn),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_rvalid_o (instr_rvalid0),
        .instr_rdata_o  (instr_rdata0),
        .data_req_i     (data_req),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_rvalid_o  (data_rvalid0),
        .data_rdata_o   (data_rdata0),
        .mem_req_o      (mem_req0),
        .mem_we_o       (mem_we0),
        .mem_be_o       (mem_be0),
        .mem_addr_o     (mem_addr0),
        .mem_wdata_o    (mem_wdata0),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata)
    );

    miriscv_mem_arbiter #(.DATA_PRIO(1'b1)) u_dut1 (
        .clk_i          (clk),
        .arstn_i        (arstn),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_rvalid_o (instr_rvalid1),
        .instr_rdata_o  (instr_rdata1),
        .data_req_i     (data_req),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_rvalid_o  (data_rvalid1),
        .data_rdata_o   (data_rdata1),
        .mem_req_o      (mem_req1),
        .mem_we_o       (mem_we1),
        .mem_be_o       (mem_be1),
        .mem_addr_o     (mem_addr1),
        .mem_wdata_o    (mem_wdata1),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 1 unit later, well clear of the next edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        arstn = 1'b0; instr_req = 1'b0; instr_addr = '0; data_req = 1'b0;
        data_we = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;
        mem_rvalid = 1'b1; mem_rdata = '0;
        tick; tick; #1;
        checks++; if (mem_req0 !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0b want 0", mem_req0); end
        checks++; if (instr_rvalid0 !== 1'b0) begin errors++; $display("FAIL reset_instr_rvalid: got %0b want 0", instr_rvalid0); end
        checks++; if (data_rvalid0 !== 1'b0) begin errors++; $display("FAIL reset_data_rvalid: got %0b want 0", data_rvalid0); end
        checks++; if ({mem_we0, mem_be0} !== 5'b0) begin errors++; $display("FAIL reset_we_be: got %0b/%h want 0/0", mem_we0, mem_be0); end
        checks++; if ({mem_addr0, mem_wdata0} !== 64'h0) begin errors++; $display("FAIL reset_addr_wdata: got %h/%h want 0/0", mem_addr0, mem_wdata0); end
        mem_rvalid = 1'b0;
        tick; arstn = 1'b1;
        tick; #1;
        checks++; if (mem_req0 !== 1'b0) begin errors++; $display("FAIL reset_release_req: got %0b want 0", mem_req0); end
    endtask

    task automatic test_instr_fetch;
        instr_req = 1'b1; instr_addr = 32'h100; #1;
        checks++; if (mem_req0 !== 1'b0) begin errors++; $display("FAIL fetch_idle_req: got %0b want 0", mem_req0); end
        tick; #1;
        checks++; if (mem_req0 !== 1'b1) begin errors++; $display("FAIL fetch_grant_req: got %0b want 1", mem_req0); end
        checks++; if (mem_addr0 !== 32'h100) begin errors++; $display("FAIL fetch_addr: got %h want 00000100", mem_addr0); end
        checks++; if (mem_be0 !== 4'hF) begin errors++; $display("FAIL fetch_be: got %h want f", mem_be0); end
        checks++; if (mem_we0 !== 1'b0) begin errors++; $display("FAIL fetch_we: got %0b want 0", mem_we0); end
        tick; #1;
        checks++; if ({mem_req0, instr_rvalid0} !== 2'b10) begin errors++; $display("FAIL fetch_wait: got req/rvalid %b want 10", {mem_req0, instr_rvalid0}); end
        tick; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
        checks++; if (instr_rvalid0 !== 1'b1) begin errors++; $display("FAIL fetch_rvalid: got %0b want 1", instr_rvalid0); end
        checks++; if (instr_rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata: got %h want deadbeef", instr_rdata0); end
        checks++; if (data_rvalid0 !== 1'b0) begin errors++; $display("FAIL fetch_data_rvalid: got %0b want 0", data_rvalid0); end
        checks++; if (mem_req0 !== 1'b0) begin errors++; $display("FAIL fetch_req_on_rvalid: got %0b want 0", mem_req0); end
        tick; instr_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; #1;
        checks++; if ({mem_req0, instr_rvalid0, data_rvalid0} !== 3'b000) begin errors++; $display("FAIL fetch_after: got %b want 000", {mem_req0, instr_rvalid0, data_rvalid0}); end
    endtask

    task automatic test_back_to_back_order;
        logic [XLEN-1:0] exp_addr0 [3];
        logic [2:0]      exp_data0;
        exp_addr0[0] = 32'h200; exp_addr0[1] = 32'h100; exp_addr0[2] = 32'h200;
        exp_data0 = 3'b101;
        arstn = 1'b0; tick; arstn = 1'b1; tick;
        instr_req = 1'b1; instr_addr = 32'h100;
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h200;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if ({mem_req0, mem_req1} !== 2'b00) begin errors++; $display("FAIL b2b_idle_%0d: got %b want 00", k, {mem_req0, mem_req1}); end
            tick; mem_rvalid = 1'b1; mem_rdata = 32'h1000 + 32'(k); #1;
            checks++; if (mem_addr0 !== exp_addr0[k]) begin errors++; $display("FAIL b2b_rr_addr_%0d: got %h want %h", k, mem_addr0, exp_addr0[k]); end
            checks++; if ({data_rvalid0, instr_rvalid0} !== {exp_data0[k], ~exp_data0[k]}) begin errors++; $display("FAIL b2b_rr_rvalid_%0d: got d/i %b want %b", k, {data_rvalid0, instr_rvalid0}, {exp_data0[k], ~exp_data0[k]}); end
            checks++; if ({mem_addr1, data_rvalid1, instr_rvalid1} !== {32'h200, 2'b10}) begin errors++; $display("FAIL b2b_prio_%0d: got %h/%b want 00000200/10", k, mem_addr1, {data_rvalid1, instr_rvalid1}); end
            checks++; if (data_rdata1 !== 32'h1000 + 32'(k)) begin errors++; $display("FAIL b2b_rdata_%0d: got %h want %h", k, data_rdata1, 32'h1000 + 32'(k)); end
            tick; mem_rvalid = 1'b0;
        end
        instr_req = 1'b0; data_req = 1'b0;
        tick;
    endtask

    task automatic test_store_stable;
        data_req = 1'b1; data_we = 1'b1; data_be = 4'b1000;
        data_addr = 32'h2003; data_wdata = 32'hAA000000; instr_req = 1'b0;
        tick; #1;
        checks++; if ({mem_req0, mem_addr0, mem_we0, mem_be0, mem_wdata0} !== {1'b1, 32'h2003, 1'b1, 4'b1000, 32'hAA000000}) begin
            errors++; $display("FAIL store_grant: got req %0b addr %h we %0b be %b wdata %h", mem_req0, mem_addr0, mem_we0, mem_be0, mem_wdata0); end
        for (int i = 0; i < 3; i++) begin
            tick; instr_req = 1'b1; instr_addr = 32'h300 + 32'(i * 4); #1;
            checks++; if ({mem_req0, mem_addr0, mem_we0, mem_be0, mem_wdata0} !== {1'b1, 32'h2003, 1'b1, 4'b1000, 32'hAA000000}) begin
                errors++; $display("FAIL store_stable_%0d: got req %0b addr %h we %0b be %b wdata %h", i, mem_req0, mem_addr0, mem_we0, mem_be0, mem_wdata0); end
            checks++; if (instr_rvalid0 !== 1'b0) begin errors++; $display("FAIL store_nonowner_%0d: got %0b want 0", i, instr_rvalid0); end
        end
        tick; instr_addr = 32'h340; mem_rvalid = 1'b1; #1;
        checks++; if ({data_rvalid0, instr_rvalid0, mem_addr0} !== {2'b10, 32'h2003}) begin errors++; $display("FAIL store_done: got d/i %b addr %h want 10/00002003", {data_rvalid0, instr_rvalid0}, mem_addr0); end
        tick; data_req = 1'b0; data_we = 1'b0; data_be = '0; data_wdata = '0; mem_rvalid = 1'b0; #1;
        checks++; if (mem_req0 !== 1'b0) begin errors++; $display("FAIL store_idle: got %0b want 0", mem_req0); end
        tick; #1;
        checks++; if ({mem_req0, mem_addr0, mem_we0, mem_be0, mem_wdata0} !== {1'b1, 32'h340, 1'b0, 4'hF, 32'h0}) begin
            errors++; $display("FAIL store_then_fetch: got req %0b addr %h we %0b be %b wdata %h", mem_req0, mem_addr0, mem_we0, mem_be0, mem_wdata0); end
        tick; mem_rvalid = 1'b1; #1;
        checks++; if (instr_rvalid0 !== 1'b1) begin errors++; $display("FAIL store_then_fetch_rvalid: got %0b want 1", instr_rvalid0); end
        tick; instr_req = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic test_kill;
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h400;
        tick; #1;
        checks++; if ({mem_req0, mem_addr0} !== {1'b1, 32'h400}) begin errors++; $display("FAIL kill_grant: got %0b/%h want 1/00000400", mem_req0, mem_addr0); end
        tick; data_req = 1'b0; #1;
        checks++; if (mem_req0 !== 1'b1) begin errors++; $display("FAIL kill_hold1: got %0b want 1", mem_req0); end
        tick; #1;
        checks++; if (mem_req0 !== 1'b1) begin errors++; $display("FAIL kill_hold2: got %0b want 1", mem_req0); end
        // The LSU raises a fresh request just as the killed response arrives.
        tick; data_req = 1'b1; data_addr = 32'h404; mem_rvalid = 1'b1; mem_rdata = 32'h55; #1;
        checks++; if ({data_rvalid0, instr_rvalid0} !== 2'b00) begin errors++; $display("FAIL kill_suppress: got d/i %b want 00", {data_rvalid0, instr_rvalid0}); end
        tick; mem_rvalid = 1'b0; #1;
        checks++; if (mem_req0 !== 1'b0) begin errors++; $display("FAIL kill_idle: got %0b want 0", mem_req0); end
        tick; #1;
        checks++; if ({mem_req0, mem_addr0} !== {1'b1, 32'h404}) begin errors++; $display("FAIL kill_regrant: got %0b/%h want 1/00000404", mem_req0, mem_addr0); end
        tick; mem_rvalid = 1'b1; #1;
        checks++; if (data_rvalid0 !== 1'b1) begin errors++; $display("FAIL kill_cleared: got %0b want 1", data_rvalid0); end
        tick; data_req = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic test_idle_rvalid;
        mem_rvalid = 1'b1; mem_rdata = 32'h99; #1;
        checks++; if ({instr_rvalid0, data_rvalid0, mem_req0} !== 3'b000) begin errors++; $display("FAIL idle_rvalid: got i/d/req %b want 000", {instr_rvalid0, data_rvalid0, mem_req0}); end
        tick; mem_rvalid = 1'b0; #1;
        checks++; if (mem_req0 !== 1'b0) begin errors++; $display("FAIL idle_rvalid_state: got %0b want 0", mem_req0); end
        instr_req = 1'b1; instr_addr = 32'h600;
        tick; #1;
        checks++; if ({mem_req0, mem_addr0} !== {1'b1, 32'h600}) begin errors++; $display("FAIL idle_then_fetch: got %0b/%h want 1/00000600", mem_req0, mem_addr0); end
        tick; mem_rvalid = 1'b1; #1;
        checks++; if (instr_rvalid0 !== 1'b1) begin errors++; $display("FAIL idle_then_fetch_rvalid: got %0b want 1", instr_rvalid0); end
        tick; instr_req = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid;
        instr_req = 1'b1; instr_addr = 32'h500;
        tick; #1;
        checks++; if (mem_req0 !== 1'b1) begin errors++; $display("FAIL rstmid_grant: got %0b want 1", mem_req0); end
        arstn = 1'b0; #1;
        checks++; if ({mem_req0, mem_addr0} !== {1'b0, 32'h0}) begin errors++; $display("FAIL rstmid_async: got %0b/%h want 0/00000000", mem_req0, mem_addr0); end
        tick; arstn = 1'b1; instr_req = 1'b0; #1;
        checks++; if (mem_req0 !== 1'b0) begin errors++; $display("FAIL rstmid_release: got %0b want 0", mem_req0); end
        tick; mem_rvalid = 1'b1; mem_rdata = 32'h77; #1;
        checks++; if ({instr_rvalid0, mem_req0} !== 2'b00) begin errors++; $display("FAIL rstmid_late_rvalid: got rvalid/req %b want 00", {instr_rvalid0, mem_req0}); end
        tick; mem_rvalid = 1'b0; #1;
        checks++; if (mem_req0 !== 1'b0) begin errors++; $display("FAIL rstmid_after: got %0b want 0", mem_req0); end
        tick; #1;
        checks++; if (mem_req0 !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: got %0b want 0", mem_req0); end
    endtask

    initial begin
        test_reset;
        test_instr_fetch;
        test_back_to_back_order;
        test_store_stable;
        test_kill;
        test_idle_rvalid;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_miriscv_mem_arbiter

// File: doc/miriscv_mem_arbiter.md
MIRISCV_MEM_ARBITER -- requirements
Module: miriscv_mem_arbiter

Interface
REQ-001 Parameter DATA_PRIO, default 0; 0 = round-robin arbitration, 1 = fixed priority to the data master. XLEN SHALL come from miriscv_pkg.
REQ-002 clk_i  in  1  single clock, all state on rising edge.
REQ-003 arstn_i  in  1  reset, asynchronous, active-low.
REQ-004 instr_req_i  in  1  fetch request, held high until instr_rvalid_o.
REQ-005 instr_addr_i  in  XLEN  fetch address.
REQ-006 instr_rvalid_o  out  1  fetch response valid, single-cycle pulse.
REQ-007 instr_rdata_o  out  XLEN  fetch response data.
REQ-008 data_req_i  in  1  LSU request, held high until data_rvalid_o; may drop early on kill.
REQ-009 data_we_i  in  1  LSU write enable.
REQ-010 data_be_i  in  XLEN/8  LSU byte enables.
REQ-011 data_addr_i  in  XLEN  LSU address.
REQ-012 data_wdata_i  in  XLEN  LSU write data.
REQ-013 data_rvalid_o  out  1  LSU response valid, single-cycle pulse.
REQ-014 data_rdata_o  out  XLEN  LSU response data.
REQ-015 mem_req_o, mem_we_o (1), mem_be_o (XLEN/8), mem_addr_o, mem_wdata_o (XLEN)  out  shared memory port request fields.
REQ-016 mem_rvalid_i  in  1  and  mem_rdata_i  in  XLEN  shared memory response.

Function
REQ-017 FSM states: IDLE, GNT_INSTR, GNT_DATA; exactly one transaction outstanding at a time.
REQ-018 IDLE: any request present -> next cycle enters GNT_x and latches the winner's addr/we/be/wdata; instr grant latches we=0, be=all ones, wdata=0.
REQ-019 Both requests in IDLE with DATA_PRIO=0 -> grant the master not granted last; last-grant register resets to "instr", so data wins the first tie.
REQ-020 DATA_PRIO=1 -> data always wins ties; last-grant register still updated.
REQ-021 mem_req_o SHALL equal (state != IDLE) & ~mem_rvalid_i; mem fields driven from latched registers only, stable for the whole grant.
REQ-022 Minimum latency: master request at cycle N -> mem_req_o at N+1 -> with zero-wait memory rvalid at N+1, master rvalid at N+1.
REQ-023 mem_rvalid_i in GNT_x -> x_rvalid_o pulses same cycle (combinational) and FSM returns to IDLE next cycle; a request present in that IDLE cycle is arbitrated normally (back-to-back throughput: one transaction per 2 cycles minimum).
REQ-024 instr_rdata_o and data_rdata_o SHALL both be driven from mem_rdata_i; only rvalid is gated per owner.
REQ-025 Owner drops its request before mem_rvalid_i (kill) -> abort flag set; transaction still completes on the memory port; response pulse suppressed; flag cleared on return to IDLE.
REQ-026 mem_rvalid_i while IDLE -> ignored, no master rvalid, no state change.
REQ-027 Non-owner requests during a grant are neither acknowledged nor latched until IDLE.

Reset
REQ-028 arstn_i low -> state IDLE, last-grant = instr, abort = 0, latched fields = 0; all outputs 0 during reset.
REQ-029 Reset mid-transaction -> outstanding transaction abandoned; its late mem_rvalid_i handled per REQ-026.

Structure
REQ-030 Package miriscv_arb_pkg SHALL hold the FSM state enum and the master-index encoding (MASTER_INSTR=0, MASTER_DATA=1).
REQ-031 Sub-module miriscv_rr_arb2 SHALL implement the 2-way combinational picker (reqs, last-grant, DATA_PRIO -> one-hot grant).

Verification
REQ-032 instr_req only, addr 0x100, memory returns 0xDEADBEEF after 2 cycles -> mem_addr_o=0x100, be=4'hF, we=0; instr_rvalid_o one pulse with 0xDEADBEEF; data_rvalid_o stays 0.
REQ-033 Both request from reset, DATA_PRIO=0 -> order data, instr, data over three back-to-back transactions; DATA_PRIO=1 -> data, data, data while data_req held.
REQ-034 Data store addr 0x2003, be=4'b1000, wdata 0xAA000000, instr_addr changes mid-grant -> mem fields constant until mem_rvalid_i.
REQ-035 Data load granted, data_req_i dropped 1 cycle later, rvalid after 3 cycles -> mem_req_o held until rvalid; no data_rvalid_o; IDLE next cycle.
REQ-036 arstn_i asserted during GNT_INSTR, rvalid arrives after release -> no instr_rvalid_o pulse; mem_req_o 0 until a new request.
